// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame geometry,
// parameter defaults and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_INHIBIT,
        TX_REQ,
        TX_SHIFT,
        TX_ACK,
        TX_RETRY
    } tx_state_t;

    localparam int FRAME_BITS         = 11;
    localparam int DEF_INHIBIT_CYCLES = 5000;
    localparam int DEF_TIMEOUT_CYCLES = 100000;
    localparam int DEF_MAX_RETRY      = 2;
    localparam int DEF_FILTER_LEN     = 8;

    // Parity bit that makes data plus parity contain an odd number of ones.
    function automatic logic odd_parity_bit(input logic [7:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// One PS/2 line: 2-FF synchroniser, FILTER_LEN-sample glitch filter and a
// registered pulse when the filtered level goes 1 -> 0.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic line,
    output logic level,
    output logic fall
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [1:0]       sync_reg;
    logic             level_reg;
    logic             fall_reg;
    logic [CNT_W-1:0] cnt_reg;

    // cnt_reg counts consecutive synchronised samples that disagree with the
    // accepted level; the FILTER_LEN-th such sample flips the level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_reg  <= 2'b11;
            level_reg <= 1'b1;
            fall_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync_reg <= {sync_reg[0], line};
            fall_reg <= 1'b0;
            if (sync_reg[1] == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(FILTER_LEN - 1)) begin
                level_reg <= sync_reg[1];
                fall_reg  <= level_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/ps2_host_txrx.sv
// PS/2 host: open-drain line drivers, host-to-device transmitter with
// request-to-send and retries, and a device-to-host receiver active when idle.
module ps2_host_txrx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int MAX_RETRY      = DEF_MAX_RETRY,
    parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
    input  logic       CLK,
    input  logic       RST,
    inout  wire        PS2CLK,
    inout  wire        PS2DATA,
    input  logic [7:0] datain,
    input  logic       tx_write,
    output logic       tx_idle,
    output logic       tx_done,
    output logic       tx_err,
    output logic [7:0] DatoRec,
    output logic       rx_valid,
    output logic       rx_err
);

    tx_state_t   state_reg, state_next;
    logic [31:0] timer_reg, timer_next;
    logic [8:0]  tx_shift_reg, tx_shift_next;
    logic [3:0]  bit_cnt_reg, bit_cnt_next;
    logic [7:0]  retry_reg, retry_next;
    logic        ack_seen_reg, ack_seen_next;
    logic        clk_low_reg, clk_low_next;
    logic        data_low_reg, data_low_next;
    logic        tx_done_reg, tx_done_next;
    logic        tx_err_reg, tx_err_next;
    logic [3:0]  rx_cnt_reg, rx_cnt_next;
    logic [9:0]  rx_shift_reg, rx_shift_next;
    logic [31:0] rx_timer_reg, rx_timer_next;
    logic [7:0]  dato_reg, dato_next;
    logic        rx_valid_reg, rx_valid_next;
    logic        rx_err_reg, rx_err_next;

    logic [1:0] line_raw;
    logic [1:0] line_level;
    logic [1:0] line_fall;
    logic       clk_level, data_level, clk_fall;
    logic       unused_data_fall;

    // Index 0 is the clock line, index 1 the data line.
    assign line_raw = {PS2DATA, PS2CLK};

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_line
        ps2_line_filter #(
            .FILTER_LEN(FILTER_LEN)
        ) u_filter (
            .CLK  (CLK),
            .RST  (RST),
            .line (line_raw[gi]),
            .level(line_level[gi]),
            .fall (line_fall[gi])
        );
    end

    assign clk_level        = line_level[0];
    assign data_level       = line_level[1];
    assign clk_fall         = line_fall[0];
    assign unused_data_fall = line_fall[1];

    assign PS2CLK  = clk_low_reg  ? 1'b0 : 1'bz;
    assign PS2DATA = data_low_reg ? 1'b0 : 1'bz;

    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg;
        tx_shift_next = tx_shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        retry_next    = retry_reg;
        ack_seen_next = ack_seen_reg;
        clk_low_next  = clk_low_reg;
        data_low_next = data_low_reg;
        tx_done_next  = 1'b0;
        tx_err_next   = 1'b0;
        rx_cnt_next   = rx_cnt_reg;
        rx_shift_next = rx_shift_reg;
        rx_timer_next = rx_timer_reg;
        dato_next     = dato_reg;
        rx_valid_next = 1'b0;
        rx_err_next   = 1'b0;

        case (state_reg)
            TX_IDLE: begin
                if (tx_write) begin
                    state_next    = TX_INHIBIT;
                    tx_shift_next = {odd_parity_bit(datain), datain};
                    timer_next    = '0;
                    retry_next    = '0;
                    clk_low_next  = 1'b1;
                    data_low_next = 1'b0;
                end
            end
            TX_INHIBIT: begin
                clk_low_next = 1'b1;
                if (timer_reg == 32'(INHIBIT_CYCLES - 1)) begin
                    state_next    = TX_REQ;
                    data_low_next = 1'b1;
                end else begin
                    timer_next = timer_reg + 32'd1;
                end
            end
            TX_REQ: begin
                clk_low_next  = 1'b0;
                data_low_next = 1'b1;
                state_next    = TX_SHIFT;
                timer_next    = '0;
                bit_cnt_next  = '0;
            end
            TX_SHIFT: begin
                // Edges 1..9 present data0..data7 and parity; edge 10 releases for stop.
                if (clk_fall) begin
                    timer_next = '0;
                    if (bit_cnt_reg == 4'd9) begin
                        data_low_next = 1'b0;
                        ack_seen_next = 1'b0;
                        state_next    = TX_ACK;
                    end else begin
                        data_low_next = ~tx_shift_reg[bit_cnt_reg];
                        bit_cnt_next  = bit_cnt_reg + 4'd1;
                    end
                end else if (timer_reg == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_next = TX_RETRY;
                end else begin
                    timer_next = timer_reg + 32'd1;
                end
            end
            TX_ACK: begin
                if (clk_fall) begin
                    timer_next = '0;
                    if (!ack_seen_reg) begin
                        if (!data_level) begin
                            ack_seen_next = 1'b1;
                        end else begin
                            state_next = TX_RETRY;
                        end
                    end
                end else if (ack_seen_reg && clk_level && data_level) begin
                    state_next   = TX_IDLE;
                    tx_done_next = 1'b1;
                end else if (timer_reg == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_next = TX_RETRY;
                end else begin
                    timer_next = timer_reg + 32'd1;
                end
            end
            TX_RETRY: begin
                clk_low_next  = 1'b0;
                data_low_next = 1'b0;
                if (retry_reg < 8'(MAX_RETRY)) begin
                    retry_next   = retry_reg + 8'd1;
                    timer_next   = '0;
                    clk_low_next = 1'b1;
                    state_next   = TX_INHIBIT;
                end else begin
                    tx_err_next = 1'b1;
                    state_next  = TX_IDLE;
                end
            end
            default: begin
                state_next    = TX_IDLE;
                clk_low_next  = 1'b0;
                data_low_next = 1'b0;
            end
        endcase

        // Receiver: bits arrive start-first; rx_shift_reg holds start..parity.
        if (state_reg != TX_IDLE || tx_write) begin
            rx_cnt_next   = '0;
            rx_timer_next = '0;
        end else if (clk_fall) begin
            rx_timer_next = '0;
            if (rx_cnt_reg == 4'(FRAME_BITS - 1)) begin
                rx_cnt_next = '0;
                if (!rx_shift_reg[0] && data_level && (^rx_shift_reg[9:1])) begin
                    dato_next     = rx_shift_reg[8:1];
                    rx_valid_next = 1'b1;
                end else begin
                    rx_err_next = 1'b1;
                end
            end else begin
                rx_shift_next = {data_level, rx_shift_reg[9:1]};
                rx_cnt_next   = rx_cnt_reg + 4'd1;
            end
        end else if (rx_cnt_reg != 4'd0) begin
            if (rx_timer_reg == 32'(TIMEOUT_CYCLES - 1)) begin
                rx_cnt_next   = '0;
                rx_timer_next = '0;
                rx_err_next   = 1'b1;
            end else begin
                rx_timer_next = rx_timer_reg + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= TX_IDLE;
            timer_reg    <= '0;
            tx_shift_reg <= '0;
            bit_cnt_reg  <= '0;
            retry_reg    <= '0;
            ack_seen_reg <= 1'b0;
            clk_low_reg  <= 1'b0;
            data_low_reg <= 1'b0;
            tx_done_reg  <= 1'b0;
            tx_err_reg   <= 1'b0;
            rx_cnt_reg   <= '0;
            rx_shift_reg <= '0;
            rx_timer_reg <= '0;
            dato_reg     <= 8'h00;
            rx_valid_reg <= 1'b0;
            rx_err_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            tx_shift_reg <= tx_shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            retry_reg    <= retry_next;
            ack_seen_reg <= ack_seen_next;
            clk_low_reg  <= clk_low_next;
            data_low_reg <= data_low_next;
            tx_done_reg  <= tx_done_next;
            tx_err_reg   <= tx_err_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_shift_reg <= rx_shift_next;
            rx_timer_reg <= rx_timer_next;
            dato_reg     <= dato_next;
            rx_valid_reg <= rx_valid_next;
            rx_err_reg   <= rx_err_next;
        end
    end

    assign tx_idle  = (state_reg == TX_IDLE);
    assign tx_done  = tx_done_reg;
    assign tx_err   = tx_err_reg;
    assign DatoRec  = dato_reg;
    assign rx_valid = rx_valid_reg;
    assign rx_err   = rx_err_reg;

endmodule
